disp_frame_sequencer: RTL
=========================

// Module: disp_frame_sequencer
// PURPOSE
//  Display-side initiator of the display/game-controller req/ack handshake. Once per video frame
//  (at vertical-blank start) it requests a game-state update, waits for the game controller's ack,
//  then publishes a coherent frame strobe. Latches the start/end-game notifications into a screen
//  mode (TITLE/PLAY/GAMEOVER) applied only on frame boundaries. Sits between VGA timing gen and renderers.
// PARAMETERS
//  CNT_W        8    width of o_frame_cnt (wraps)
//  BLINK_FRAMES 30   accepted frames per o_blink toggle (>=1)
//  MISS_W       4    width of saturating o_miss_cnt
//  TIMEOUT_CYC  4096 req timeout in clk cycles (used only with DISP_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in  1      system clock; single clock domain
//  rst          in  1      synchronous reset, active-high
//  i_vsync_start in 1      1-cycle pulse at start of vertical blank
//  i_vblank     in  1      high during vertical blank
//  o_req        out 1      request to game controller (its disp_ctrl req input)
//  i_ack        in  1      ack from game controller (level or pulse)
//  i_startgame  in  1      1-cycle pulse: game started
//  i_endgame    in  1      1-cycle pulse: game ended
//  o_frame_valid out 1     1-cycle pulse: frame accepted, renderers latch state
//  o_screen_mode out 2     0=TITLE 1=PLAY 2=GAMEOVER (3 never driven)
//  o_frame_cnt  out CNT_W  accepted-frame counter
//  o_blink      out 1      blink phase for overlay text
//  o_miss_cnt   out MISS_W saturating count of dropped/aborted frames
//  o_busy       out 1      high whenever FSM not IDLE
// BEHAVIOUR
//  Reset (rst=1 at clk edge): FSM=IDLE; o_req=0, o_frame_valid=0, o_screen_mode=TITLE,
//   pending mode=TITLE, o_frame_cnt=0, o_blink=0, blink counter=0, o_miss_cnt=0, o_busy=0.
//   Reset mid-handshake drops o_req next cycle; no frame_valid issued.
//  FSM (four-phase handshake), all outputs registered:
//   IDLE: i_vsync_start -> REQ; o_req=1 from next cycle.
//   REQ: o_req held 1. i_ack=1 -> o_frame_valid pulses next cycle, o_req=0 next cycle, -> ACKLO.
//        Abort: i_vblank=0 with i_ack=0 -> o_req=0, o_miss_cnt+1, no frame_valid, -> ACKLO.
//        Ack and vblank fall same cycle: ack wins (frame accepted).
//   ACKLO: wait i_ack=0 (1 cycle min) -> IDLE. Never re-asserts o_req while i_ack high.
//  i_vsync_start while FSM!=IDLE: ignored, o_miss_cnt+1. Same-cycle abort+ignored vsync: +1 only.
//  o_miss_cnt saturates at 2^MISS_W-1; never wraps.
//  Latency: vsync_start->o_req = 1 cycle; ack sample->o_frame_valid = 1 cycle.
//  Screen mode: pending register updated any cycle: i_startgame -> PLAY, i_endgame -> GAMEOVER;
//   both same cycle -> GAMEOVER. o_screen_mode <= pending on the o_frame_valid cycle only;
//   notification arriving on the accept cycle is included in that frame.
//  On each o_frame_valid: o_frame_cnt+1 (mod 2^CNT_W); blink counter+1; at BLINK_FRAMES-1
//   it clears and o_blink toggles. Aborted frames advance nothing.
// CONFIGURATION
//  DISP_SEQ_TIMEOUT_EN defined: REQ also aborts after TIMEOUT_CYC cycles without ack (counter
//   cleared on REQ entry), same effects as vblank abort; whichever occurs first. Ack on timeout
//   cycle wins. Undefined: no timeout counter; abort only on vblank end.
// TESTING
//  1 vsync pulse, ack high 3 cycles later for 2 cycles -> req high 4 cycles, one frame_valid,
//    frame_cnt=1, busy low after ack low.
//  2 startgame pulse mid-frame, then handshake -> screen_mode stays TITLE until frame_valid, then 1;
//    startgame+endgame same cycle -> 2 on next frame_valid.
//  3 vsync, no ack, vblank falls after 20 cycles -> req drops, miss_cnt=1, frame_cnt unchanged;
//    17 misses with MISS_W=4 -> miss_cnt=15.
//  4 60 accepted frames, BLINK_FRAMES=30 -> blink toggles at frames 30 and 60; 256 frames ->
//    frame_cnt wraps to 0.
//  5 rst asserted in REQ -> req=0 next cycle, all outputs at reset values; ack held high
//    after vsync -> req not reasserted until ack low.
//  6 DISP_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, vblank held high, no ack -> abort after 16 cycles,
//    miss_cnt=1; ack on cycle 16 -> frame accepted.

Source files
------------

// File: rtl/disp_frame_sequencer.sv
// Per-frame req/ack initiator toward the game controller, with frame-boundary screen-mode latching.
// Optional macro DISP_SEQ_TIMEOUT_EN adds a REQ-phase timeout abort after TIMEOUT_CYC cycles.
module disp_frame_sequencer #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned MISS_W       = 4,
    parameter int unsigned TIMEOUT_CYC  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vsync_start,
    input  logic              i_vblank,
    output logic              o_req,
    input  logic              i_ack,
    input  logic              i_startgame,
    input  logic              i_endgame,
    output logic              o_frame_valid,
    output logic [1:0]        o_screen_mode,
    output logic [CNT_W-1:0]  o_frame_cnt,
    output logic              o_blink,
    output logic [MISS_W-1:0] o_miss_cnt,
    output logic              o_busy
);

    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [1:0] ModeTitle    = 2'd0;
    localparam logic [1:0] ModePlay     = 2'd1;
    localparam logic [1:0] ModeGameOver = 2'd2;

    typedef enum logic [1:0] {StIdle, StReq, StAckLo} state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              fv_q, fv_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        pending_q, pending_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              blink_q, blink_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              busy_q, busy_d;
    logic              accept, abort, miss_inc, timeout;

`ifdef DISP_SEQ_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] tmo_q, tmo_d;

    // tmo_q holds the index of the current REQ cycle; zero on REQ entry.
    assign timeout = (state_q == StReq) && (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign tmo_d   = (state_q == StReq) ? tmo_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        fv_d    = 1'b0;
        accept  = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_vsync_start) begin
                    state_d = StReq;
                    req_d   = 1'b1;
                end
            end
            StReq: begin
                // Ack takes priority over both vblank end and timeout.
                if (i_ack) begin
                    accept  = 1'b1;
                    fv_d    = 1'b1;
                    req_d   = 1'b0;
                    state_d = StAckLo;
                end else if (!i_vblank || timeout) begin
                    abort   = 1'b1;
                    req_d   = 1'b0;
                    state_d = StAckLo;
                end
            end
            StAckLo: begin
                if (!i_ack) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_comb begin
        pending_d = pending_q;
        if (i_endgame)        pending_d = ModeGameOver;
        else if (i_startgame) pending_d = ModePlay;

        mode_d      = mode_q;
        cnt_d       = cnt_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (accept) begin
            mode_d = pending_d;
            cnt_d  = cnt_q + 1'b1;
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        // An abort coinciding with an ignored vsync counts as a single miss.
        miss_inc = abort || (i_vsync_start && (state_q != StIdle));
        miss_d   = miss_q;
        if (miss_inc && (miss_q != {MISS_W{1'b1}})) miss_d = miss_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            fv_q        <= 1'b0;
            mode_q      <= ModeTitle;
            pending_q   <= ModeTitle;
            cnt_q       <= '0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
            miss_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            fv_q        <= fv_d;
            mode_q      <= mode_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            miss_q      <= miss_d;
            busy_q      <= busy_d;
        end
    end

    assign o_req         = req_q;
    assign o_frame_valid = fv_q;
    assign o_screen_mode = mode_q;
    assign o_frame_cnt   = cnt_q;
    assign o_blink       = blink_q;
    assign o_miss_cnt    = miss_q;
    assign o_busy        = busy_q;

endmodule
